sys_mode_ctrl: RTL and testbench
================================

Name: sys_mode_ctrl

Overview:
Parametrised board-input and pipeline-control block that supersedes the fixed two-mode controller. It debounces next/previous/reconfigure buttons and cycles through NUM_MODES display modes with wrap-around. It gates NUM_FILTERS filter-enable switches by mode and supervises camera configuration with a done handshake, timeout and bounded retry. It sits between board I/O and the camera-config and video-pipeline blocks.

Parameters:
NUM_MODES, 4, number of pipeline modes; mode 0 is passthrough; must be >= 2.
NUM_FILTERS, 2, number of filter-enable switches and outputs.
DB_COUNT, 500_000, consecutive stable cycles required before a debounced button changes (20 ms at 25 MHz).
CFG_TIMEOUT, 50_000_000, cycles to wait for i_cfg_done after each o_cfg_start.
CFG_RETRIES, 3, extra start attempts after the first timeout before declaring error.
MODE_W is a derived localparam: clog2(NUM_MODES), minimum 1.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_btn_next  in  1  raw async button: advance mode
i_btn_prev  in  1  raw async button: step mode back
i_btn_recfg  in  1  raw async button: re-run camera config
i_sw_filter  in  NUM_FILTERS  raw async filter-enable switches
i_cfg_done  in  1  single-cycle pulse from camera config block: config complete
o_cfg_start  out  1  single-cycle config start pulse
o_mode  out  MODE_W  current mode
o_mode_changed  out  1  single-cycle pulse, same cycle o_mode takes its new value
o_filter_en  out  NUM_FILTERS  gated filter enables
o_status_leds  out  8  status display

Behaviour:
- One clock. Reset is synchronous and active-high: i_rst is sampled on the rising edge of i_clk.
- Reset values: state=S_START, o_mode=0, o_mode_changed=0, o_filter_en=0, retry count=0, timer=0, debounced buttons=0, sync flops=0.
- Input conditioning:
  - Every raw input, including the switches, passes through a 2-flop synchronizer.
  - Each button has its own debounce counter. The counter clears whenever the synced input equals the debounced value. When the counter reaches DB_COUNT-1, the debounced value takes the synced value and the counter clears.
  - Rising-edge detect on the debounced value produces a 1-cycle event. Press-to-event latency is DB_COUNT+3 cycles.
  - Switches are not debounced.
- Config FSM:
  - S_START: o_cfg_start=1 for this single cycle; timer cleared; go to S_WAIT.
  - S_WAIT: timer increments each cycle.
    - i_cfg_done=1: go to S_ACTIVE and clear the retry count. This takes priority over timeout in the same cycle.
    - Else timer==CFG_TIMEOUT-1 and retry count<CFG_RETRIES: increment retry count, go to S_START.
    - Else timer==CFG_TIMEOUT-1: go to S_ERROR.
  - S_ACTIVE: a recfg event returns to S_START with the retry count cleared. i_cfg_done is ignored.
  - S_ERROR: a recfg event returns to S_START with the retry count cleared. i_cfg_done is ignored.
  - In S_START and S_WAIT, recfg events are discarded.
  - o_cfg_start is high in the first cycle after reset deasserts. Total attempts before error = CFG_RETRIES+1.
- Mode:
  - Mode events are accepted only in S_ACTIVE; events in any other state are discarded, not queued.
  - A next event gives mode+1; NUM_MODES-1 wraps to 0.
  - A prev event gives mode-1; 0 wraps to NUM_MODES-1.
  - Next and prev events in the same cycle: no change and no o_mode_changed.
  - o_mode is registered; it updates and o_mode_changed pulses 1 cycle after the event.
  - Reset mid-operation returns o_mode to 0.
- Filter gating:
  - o_filter_en is registered: 0 when o_mode==0, else the synced i_sw_filter.
  - Switch-to-output latency is 3 cycles.
  - Entering mode 0 clears o_filter_en on the cycle after o_mode becomes 0.
- LEDs (combinational from registers):
  - [0] = state==S_ACTIVE.
  - [1] = state==S_ERROR.
  - [2] = state is S_START or S_WAIT.
  - [4:3] = retry count, saturating at 3.
  - [7:5] = o_mode zero-extended or truncated to 3 bits.

Test Plan:
- Reset, DB_COUNT=4, CFG_TIMEOUT=100: release reset -> o_cfg_start=1 in exactly one cycle (the first after reset); i_cfg_done pulse 10 cycles later -> o_status_leds[0]=1, [2]=0.
- Never assert i_cfg_done, CFG_RETRIES=3 -> exactly 4 o_cfg_start pulses spaced 101 cycles apart, then o_status_leds[1]=1; a recfg press (held 10 cycles) -> new o_cfg_start, LEDs[4:3]=0.
- In S_ACTIVE, NUM_MODES=3: 3 next presses -> o_mode 1,2,0, each with one o_mode_changed pulse; a prev press at 0 -> 2; next+prev events in the same cycle -> o_mode unchanged, no pulse.
- Button bounce: toggle i_btn_next every 2 cycles for 20 cycles, then hold high -> exactly one mode increment, occurring DB_COUNT+3 cycles after the final edge.
- i_sw_filter=2'b11 with o_mode=0 -> o_filter_en=0; advance to mode 1 -> o_filter_en=2'b11 one cycle after o_mode changes; toggle the switch -> output follows 3 cycles later.
- Mode press during S_WAIT -> ignored, o_mode stays put; i_rst asserted while in mode 2 in S_ACTIVE -> o_mode=0, o_filter_en=0 next cycle, config restarts.

Source files
------------

// File: rtl/sys_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sys_mode_ctrl
//  Purpose  : Board-input and pipeline-control block. Synchronises and
//             debounces the next/prev/reconfigure buttons, steps through
//             NUM_MODES display modes with wrap-around, gates the filter
//             enable switches by mode, and supervises camera configuration
//             with a done handshake, per-attempt timeout and bounded retry.
//  Ports    :
//    i_clk           system clock
//    i_rst           synchronous active-high reset
//    i_btn_next      raw async button, advance mode
//    i_btn_prev      raw async button, step mode back
//    i_btn_recfg     raw async button, re-run camera config
//    i_sw_filter     raw async filter-enable switches [NUM_FILTERS]
//    i_cfg_done      1-cycle pulse from camera config block
//    o_cfg_start     1-cycle config start pulse
//    o_mode          current mode [MODE_W]
//    o_mode_changed  1-cycle pulse in the cycle o_mode takes a new value
//    o_filter_en     gated filter enables [NUM_FILTERS]
//    o_status_leds   status display [8]
//  Revision : 1.0  initial release
// ============================================================================
module sys_mode_ctrl #(
  parameter int NUM_MODES   = 4,
  parameter int NUM_FILTERS = 2,
  parameter int DB_COUNT    = 500_000,
  parameter int CFG_TIMEOUT = 50_000_000,
  parameter int CFG_RETRIES = 3,
  localparam int MODE_W     = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_btn_next,
  input  logic                   i_btn_prev,
  input  logic                   i_btn_recfg,
  input  logic [NUM_FILTERS-1:0] i_sw_filter,
  input  logic                   i_cfg_done,
  output logic                   o_cfg_start,
  output logic [MODE_W-1:0]      o_mode,
  output logic                   o_mode_changed,
  output logic [NUM_FILTERS-1:0] o_filter_en,
  output logic [7:0]             o_status_leds
);

  localparam int DB_W  = (DB_COUNT > 1)    ? $clog2(DB_COUNT)        : 1;
  localparam int TMR_W = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT)     : 1;
  localparam int RTY_W = (CFG_RETRIES > 0) ? $clog2(CFG_RETRIES + 1) : 1;

  // Button lanes share one debounce structure
  localparam int NBTN      = 3;
  localparam int BTN_NEXT  = 0;
  localparam int BTN_PREV  = 1;
  localparam int BTN_RECFG = 2;

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_ERROR  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic [NBTN-1:0]        btn_raw;
  logic [NBTN-1:0]        btn_s1_q, btn_s2_q;
  logic [NUM_FILTERS-1:0] sw_s1_q, sw_s2_q;

  assign btn_raw = {i_btn_recfg, i_btn_prev, i_btn_next};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= i_sw_filter;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: a lane only changes after DB_COUNT consecutive cycles of the
  // synced input disagreeing with the debounced value. Any agreement restarts
  // the count, so bounces shorter than that are absorbed.
  // --------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];
  logic [NBTN-1:0] db_q, db_d;
  logic [NBTN-1:0] db_dly_q;
  logic [NBTN-1:0] btn_ev;

  always_comb begin
    db_d = db_q;
    for (int b = 0; b < NBTN; b++) begin
      db_cnt_d[b] = '0;
      if (btn_s2_q[b] != db_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DB_COUNT - 1)) begin
          db_d[b] = btn_s2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NBTN; b++) begin
        db_cnt_q[b] <= '0;
      end
      db_q     <= '0;
      db_dly_q <= '0;
    end else begin
      for (int b = 0; b < NBTN; b++) begin
        db_cnt_q[b] <= db_cnt_d[b];
      end
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  // Press events: one cycle, on the rising edge of the debounced level
  assign btn_ev = db_q & ~db_dly_q;

  // --------------------------------------------------------------------------
  // Configuration supervisor FSM
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             cfg_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_START;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    cfg_start = 1'b0;
    case (state_q)
      S_START: begin
        cfg_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A done arriving in the timeout cycle still counts as success
        if (i_cfg_done) begin
          retry_d = '0;
          state_d = S_ACTIVE;
        end else if (timer_q == TMR_W'(CFG_TIMEOUT - 1)) begin
          if (retry_q < RTY_W'(CFG_RETRIES)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_START;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ACTIVE, S_ERROR: begin
        timer_d = '0;
        if (btn_ev[BTN_RECFG]) begin
          retry_d = '0;
          state_d = S_START;
        end
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  // The FSM sits in S_START throughout reset; only the first cycle after
  // reset is released may show the start pulse.
  assign o_cfg_start = cfg_start & ~i_rst;

  // --------------------------------------------------------------------------
  // Mode register and filter gating
  // --------------------------------------------------------------------------
  logic [MODE_W-1:0]      mode_q, mode_d;
  logic                   mode_chg_q, mode_chg_d;
  logic [NUM_FILTERS-1:0] filter_q, filter_d;

  always_comb begin
    mode_d     = mode_q;
    mode_chg_d = 1'b0;
    // Simultaneous next and prev cancel; events outside S_ACTIVE are dropped
    if ((state_q == S_ACTIVE) && (btn_ev[BTN_NEXT] ^ btn_ev[BTN_PREV])) begin
      mode_chg_d = 1'b1;
      if (btn_ev[BTN_NEXT]) begin
        if (mode_q == MODE_W'(NUM_MODES - 1)) begin
          mode_d = '0;
        end else begin
          mode_d = mode_q + MODE_W'(1);
        end
      end else begin
        if (mode_q == '0) begin
          mode_d = MODE_W'(NUM_MODES - 1);
        end else begin
          mode_d = mode_q - MODE_W'(1);
        end
      end
    end
  end

  // Mode 0 is passthrough: filters forced off, keyed on the registered mode
  always_comb begin
    filter_d = '0;
    if (mode_q != '0) begin
      filter_d = sw_s2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q     <= '0;
      mode_chg_q <= 1'b0;
      filter_q   <= '0;
    end else begin
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
      filter_q   <= filter_d;
    end
  end

  assign o_mode         = mode_q;
  assign o_mode_changed = mode_chg_q;
  assign o_filter_en    = filter_q;

  // --------------------------------------------------------------------------
  // Status LEDs
  // --------------------------------------------------------------------------
  logic [1:0] led_retry;

  always_comb begin
    led_retry = 2'(retry_q);
    if (32'(retry_q) > 32'd3) begin
      led_retry = 2'd3;
    end
  end

  assign o_status_leds = {3'(mode_q),
                          led_retry,
                          (state_q == S_START) || (state_q == S_WAIT),
                          (state_q == S_ERROR),
                          (state_q == S_ACTIVE)};

endmodule
`default_nettype wire

// File: tb/tb_sys_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_mode_ctrl
//  Purpose  : Self-checking bench for sys_mode_ctrl with NUM_MODES=3,
//             DB_COUNT=4, CFG_TIMEOUT=100, CFG_RETRIES=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sys_mode_ctrl;

  localparam int NUM_MODES   = 3;
  localparam int NUM_FILTERS = 2;
  localparam int DB_COUNT    = 4;
  localparam int CFG_TIMEOUT = 100;
  localparam int CFG_RETRIES = 3;
  localparam int MODE_W      = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   btn_next, btn_prev, btn_recfg;
  logic [NUM_FILTERS-1:0] sw_filter;
  logic                   cfg_done;
  logic                   cfg_start;
  logic [MODE_W-1:0]      mode;
  logic                   mode_changed;
  logic [NUM_FILTERS-1:0] filter_en;
  logic [7:0]             leds;

  sys_mode_ctrl #(
    .NUM_MODES  (NUM_MODES),
    .NUM_FILTERS(NUM_FILTERS),
    .DB_COUNT   (DB_COUNT),
    .CFG_TIMEOUT(CFG_TIMEOUT),
    .CFG_RETRIES(CFG_RETRIES)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_next    (btn_next),
    .i_btn_prev    (btn_prev),
    .i_btn_recfg   (btn_recfg),
    .i_sw_filter   (sw_filter),
    .i_cfg_done    (cfg_done),
    .o_cfg_start   (cfg_start),
    .o_mode        (mode),
    .o_mode_changed(mode_changed),
    .o_filter_en   (filter_en),
    .o_status_leds (leds)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       nxt;
    logic       prv;
    logic [1:0] exp_mode;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cnt;
    int pulses;
    int first;
    int starts [$];

    vecs[0] = '{1'b1, 1'b0, 2'd1, 1};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 1};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 1};
    vecs[3] = '{1'b0, 1'b1, 2'd2, 1};
    vecs[4] = '{1'b1, 1'b1, 2'd2, 0};
    vecs[5] = '{1'b0, 1'b1, 2'd1, 1};
    vecs[6] = '{1'b1, 1'b0, 2'd2, 1};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 1};

    rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; btn_recfg = 1'b0;
    sw_filter = '0; cfg_done = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_mode",      32'(mode), 0);
    chk("rst_changed",   32'(mode_changed), 0);
    chk("rst_filter",    32'(filter_en), 0);
    chk("rst_cfg_start", 32'(cfg_start), 0);
    chk("rst_leds",      32'(leds), 32'h04);

    rst = 1'b0;
    #1;
    chk("cfg_start_first", 32'(cfg_start), 1);
    cnt = 0;
    repeat (9) begin
      tick();
      if (cfg_start) cnt++;
    end
    chk("cfg_start_single", cnt, 0);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    chk("active_leds", 32'(leds), 32'h01);

    // ---------------- mode stepping table ----------------
    for (int v = 0; v < 8; v++) begin
      btn_next = vecs[v].nxt;
      btn_prev = vecs[v].prv;
      pulses = 0;
      repeat (12) begin
        tick();
        if (mode_changed) pulses++;
      end
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (12) begin
        tick();
        if (mode_changed) pulses++;
      end
      chk($sformatf("vec%0d_mode", v), 32'(mode), 32'(vecs[v].exp_mode));
      chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
    end

    // ---------------- filters in mode 0 ----------------
    sw_filter = 2'b11;
    repeat (5) tick();
    chk("filt_mode0", 32'(filter_en), 0);

    // ---------------- bounce then hold ----------------
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_next = (i % 2 == 0);
      repeat (2) begin
        tick();
        if (mode_changed) pulses++;
      end
    end
    chk("bounce_no_event", pulses, 0);
    btn_next = 1'b1;
    first = -1;
    pulses = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (mode_changed) begin
        pulses++;
        if (first < 0) first = t;
      end
      if (t == 7) chk("filt_same_cycle", 32'(filter_en), 0);
      if (t == 8) chk("filt_follow_mode", 32'(filter_en), 32'h3);
    end
    chk("bounce_latency", first, DB_COUNT + 3);
    chk("bounce_pulses", pulses, 1);
    chk("bounce_mode", 32'(mode), 1);
    btn_next = 1'b0;
    repeat (10) tick();
    chk("leds_mode1", 32'(leds), 32'h21);

    // switch change reaches the output on the third edge
    sw_filter = 2'b01;
    tick();
    tick();
    chk("sw_lat_2", 32'(filter_en), 32'h3);
    tick();
    chk("sw_lat_3", 32'(filter_en), 32'h1);

    // ---------------- recfg from ACTIVE ----------------
    btn_recfg = 1'b1;
    cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) btn_recfg = 1'b0;
      tick();
      if (cfg_start) cnt++;
    end
    chk("recfg_active_start", cnt, 1);
    chk("wait_leds", 32'(leds), 32'h24);

    // mode press while waiting for config is dropped
    btn_next = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (mode_changed) pulses++;
    end
    btn_next = 1'b0;
    repeat (12) begin
      tick();
      if (mode_changed) pulses++;
    end
    chk("wait_mode_hold", 32'(mode), 1);
    chk("wait_no_pulse", pulses, 0);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    chk("reactive_leds", 32'(leds), 32'h21);

    // advance to mode 2
    btn_next = 1'b1;
    repeat (12) tick();
    btn_next = 1'b0;
    repeat (12) tick();
    chk("mode2", 32'(mode), 2);
    chk("mode2_filter", 32'(filter_en), 32'h1);

    // ---------------- reset mid-operation ----------------
    rst = 1'b1;
    tick();
    chk("midrst_mode",   32'(mode), 0);
    chk("midrst_filter", 32'(filter_en), 0);
    chk("midrst_leds",   32'(leds), 32'h04);
    rst = 1'b0;
    #1;
    chk("midrst_cfg_start", 32'(cfg_start), 1);

    // ---------------- timeout and retries ----------------
    for (int t = 1; t <= 450; t++) begin
      tick();
      if (cfg_start) starts.push_back(t);
      if (t == 403) chk("pre_error_leds", 32'(leds), 32'h1C);
      if (t == 404) chk("error_leds", 32'(leds), 32'h1A);
    end
    chk("retry_pulses", starts.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("retry_start%0d", k),
          (k < starts.size()) ? starts[k] : -1, 101 * (k + 1));
    end

    // ---------------- recfg from ERROR ----------------
    btn_recfg = 1'b1;
    cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) btn_recfg = 1'b0;
      tick();
      if (cfg_start) begin
        cnt++;
        chk("recfg_err_retry", 32'(leds[4:3]), 0);
      end
    end
    chk("recfg_err_start", cnt, 1);
    chk("recfg_err_leds", 32'(leds), 32'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
